// File: rtl/star.sv
// -----------------------------------------------------------------------------
// star -- vector max / exponent-sum sequencer
//
// Walks a 256-byte input space as 16 vectors of 16 signed elements.
// Each vector goes through the same fixed 50-cycle schedule:
//   LOAD(16) -> CAMSUB(16) -> GAP(1) -> FINDSUB(16) -> DRAIN(1)
// The element buffer is loaded first. Each element is then shown to an
// external CAM, and the one-hot match vectors are ORed to find the vector
// maximum. The elements are then shown again for the external subtract/
// exponent lookup, and the returned exponents are summed. When the last
// vector has drained, the block parks in DONE with finish held high.
//
// Ports
//   clk          in   1  clock, all state on rising edge
//   reset        in   1  asynchronous active-high reset
//   data         in   8  element byte for the address on data_addr
//   data_req     out  1  high during LOAD
//   data_addr    out  9  input byte address 0..255, holds outside LOAD
//   i_xi_MV      in  64  CAM one-hot match for xi, valid with CAMSUB_req
//   CAMSUB_req   out  1  high during CAMSUB
//   xi           out  8  element presented in CAMSUB/FINDSUB, else 0
//   o_xmax_MV    out 64  one-hot of the highest matched CAM bit
//   o_xi_MV      out 64  last sampled i_xi_MV
//   FindSub_req  out  1  high during FINDSUB
//   i_sub_MV     in  64  subtraction match, one cycle after FindSub_req
//   exp          in   8  exponent, sampled together with i_sub_MV
//   Sum_exp      in   8  offset added to the exponent sum
//   o_sub_MV     out 64  last sampled i_sub_MV
//   o_sum_MV     out 64  one-hot of the saturated exponent sum
//   finish       out  1  all vectors processed, held high
// -----------------------------------------------------------------------------
module star (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  output logic        data_req,
  output logic [8:0]  data_addr,
  input  logic [63:0] i_xi_MV,
  output logic        CAMSUB_req,
  output logic [7:0]  xi,
  output logic [63:0] o_xmax_MV,
  output logic [63:0] o_xi_MV,
  output logic        FindSub_req,
  input  logic [63:0] i_sub_MV,
  input  logic [7:0]  exp,
  input  logic [7:0]  Sum_exp,
  output logic [63:0] o_sub_MV,
  output logic [63:0] o_sum_MV,
  output logic        finish
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAMSUB  = 3'd2,
    GAP     = 3'd3,
    FINDSUB = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic [7:0]  elemBuf_q [16];
  logic [7:0]  elemBuf_d [16];
  logic [8:0]  addrHold_q, addrHold_d;
  logic [63:0] accXi_q, accXi_d;
  logic [11:0] accExp_q, accExp_d;
  logic [63:0] xmax_q, xmax_d;
  logic [63:0] oXi_q, oXi_d;
  logic [63:0] oSub_q, oSub_d;
  logic [63:0] oSum_q, oSum_d;

  logic        lastCycle;
  logic [8:0]  curAddr;
  logic        sampleSub;
  logic [63:0] accXiNext;
  logic [11:0] accExpNext;
  logic [12:0] sumTotal;
  logic [5:0]  sumSat;

  // One-hot of the most significant set bit; zero input gives zero.
  function automatic logic [63:0] msbOneHot(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) r = 64'd1 << i;
    end
    return r;
  endfunction

  assign lastCycle = (cnt_q == 4'd15);
  assign curAddr   = {1'b0, vec_q, cnt_q};

  // State, phase counter and vector counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  // Sequencing: every 16-cycle phase counts cnt 0..15 and wraps into the
  // next phase, so each phase starts its element index at 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    data_req    = 1'b0;
    CAMSUB_req  = 1'b0;
    FindSub_req = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
        cnt_d   = '0;
        vec_d   = '0;
      end
      LOAD: begin
        data_req = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (lastCycle) state_d = CAMSUB;
      end
      CAMSUB: begin
        CAMSUB_req = 1'b1;
        cnt_d      = cnt_q + 4'd1;
        if (lastCycle) state_d = GAP;
      end
      GAP: begin
        // Single idle cycle so external element counters see a clean restart.
        cnt_d   = '0;
        state_d = FINDSUB;
      end
      FINDSUB: begin
        FindSub_req = 1'b1;
        cnt_d       = cnt_q + 4'd1;
        if (lastCycle) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = '0;
        if (vec_q == 4'd15) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
          vec_d   = vec_q + 4'd1;
        end
      end
      DONE: begin
        finish = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers: element buffer, held address, accumulators and
  // the registered match-vector outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) elemBuf_q[i] <= '0;
      addrHold_q <= '0;
      accXi_q    <= '0;
      accExp_q   <= '0;
      xmax_q     <= '0;
      oXi_q      <= '0;
      oSub_q     <= '0;
      oSum_q     <= '0;
    end else begin
      elemBuf_q  <= elemBuf_d;
      addrHold_q <= addrHold_d;
      accXi_q    <= accXi_d;
      accExp_q   <= accExp_d;
      xmax_q     <= xmax_d;
      oXi_q      <= oXi_d;
      oSub_q     <= oSub_d;
      oSum_q     <= oSum_d;
    end
  end

  // Exponent returns lag FindSub_req by one cycle, so sampling runs from
  // the second FINDSUB cycle through DRAIN.
  assign sampleSub  = ((state_q == FINDSUB) && (cnt_q != 4'd0)) || (state_q == DRAIN);
  assign accXiNext  = accXi_q | i_xi_MV;
  assign accExpNext = accExp_q + {4'b0, exp};
  assign sumTotal   = {1'b0, accExpNext} + {5'b0, Sum_exp};
  assign sumSat     = (sumTotal > 13'd63) ? 6'd63 : sumTotal[5:0];

  // Next-state values for the datapath.
  always_comb begin
    elemBuf_d  = elemBuf_q;
    addrHold_d = addrHold_q;
    accXi_d    = accXi_q;
    accExp_d   = accExp_q;
    xmax_d     = xmax_q;
    oXi_d      = oXi_q;
    oSub_d     = oSub_q;
    oSum_d     = oSum_q;

    if (state_q == LOAD) begin
      elemBuf_d[cnt_q] = data;
      addrHold_d       = curAddr;
    end

    if (state_q == CAMSUB) begin
      oXi_d   = i_xi_MV;
      accXi_d = accXiNext;
      // The final match is folded in before the maximum is taken.
      if (lastCycle) xmax_d = msbOneHot(accXiNext);
    end

    if (sampleSub) begin
      oSub_d   = i_sub_MV;
      accExp_d = accExpNext;
    end

    if (state_q == DRAIN) begin
      oSum_d = 64'd1 << sumSat;
    end

    // A new vector starts with empty accumulators; this overrides the
    // DRAIN update because the sum has already been consumed.
    if ((state_d == LOAD) && (state_q != LOAD)) begin
      accXi_d  = '0;
      accExp_d = '0;
    end
  end

  assign data_addr = (state_q == LOAD) ? curAddr : addrHold_q;
  assign xi        = ((state_q == CAMSUB) || (state_q == FINDSUB)) ? elemBuf_q[cnt_q] : 8'd0;
  assign o_xmax_MV = xmax_q;
  assign o_xi_MV   = oXi_q;
  assign o_sub_MV  = oSub_q;
  assign o_sum_MV  = oSum_q;

endmodule

// File: tb/tb_star.sv
// -----------------------------------------------------------------------------
// tb_star -- self-checking bench for star
//
// The environment here is made of three parts. A byte memory answers
// data_addr. A one-hot CAM model (bit = x + 20) answers xi while
// CAMSUB_req is high. Per-vector tables supply the exponent and
// subtraction returns. Expected outputs come from the vector contents:
// the maximum element in range and the saturated exponent sum. They are
// placed on a fixed 50-cycle-per-vector timeline.
// -----------------------------------------------------------------------------
module tb_star;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data;
  logic        data_req;
  logic [8:0]  data_addr;
  logic [63:0] i_xi_MV;
  logic        CAMSUB_req;
  logic [7:0]  xi;
  logic [63:0] o_xmax_MV;
  logic [63:0] o_xi_MV;
  logic        FindSub_req;
  logic [63:0] subIn;
  logic [7:0]  expIn;
  logic [7:0]  sumExpIn;
  logic [63:0] o_sub_MV;
  logic [63:0] o_sum_MV;
  logic        finish;

  logic [7:0]  mem [256];
  logic [7:0]  expTab [16][16];
  logic [63:0] subTab [16][16];
  logic [63:0] junkXi;

  int vectors = 0;
  int errors  = 0;

  star dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .data_req    (data_req),
    .data_addr   (data_addr),
    .i_xi_MV     (i_xi_MV),
    .CAMSUB_req  (CAMSUB_req),
    .xi          (xi),
    .o_xmax_MV   (o_xmax_MV),
    .o_xi_MV     (o_xi_MV),
    .FindSub_req (FindSub_req),
    .i_sub_MV    (subIn),
    .exp         (expIn),
    .Sum_exp     (sumExpIn),
    .o_sub_MV    (o_sub_MV),
    .o_sum_MV    (o_sum_MV),
    .finish      (finish)
  );

  always #5 clk = ~clk;

  // One-hot CAM: element x matches bit x+20 when that bit exists.
  function automatic logic [63:0] camModel(input logic [7:0] x);
    int xv;
    xv = $signed(x);
    if (xv >= -20 && xv <= 43) return 64'd1 << (xv + 20);
    return 64'd0;
  endfunction

  // Largest in-range element of vector v, as a CAM one-hot.
  function automatic logic [63:0] xmaxModel(input int v);
    int best;
    int x;
    best = -1;
    for (int k = 0; k < 16; k++) begin
      x = $signed(mem[16 * v + k]);
      if (x >= -20 && x <= 43 && (x + 20) > best) best = x + 20;
    end
    if (best < 0) return 64'd0;
    return 64'd1 << best;
  endfunction

  // Sum of the 16 returned exponents plus offset, saturated at 63.
  function automatic logic [63:0] sumModel(input int v);
    int s;
    s = int'(sumExpIn);
    for (int j = 0; j < 16; j++) s += int'(expTab[v][j]);
    if (s > 63) s = 63;
    return 64'd1 << s;
  endfunction

  assign data    = mem[data_addr[7:0]];
  assign i_xi_MV = CAMSUB_req ? camModel(xi) : junkXi;

  task automatic chk(input string tag, input int t, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want)
    else begin
      errors++;
      $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, want);
    end
  endtask

  // Everything must read zero while reset is (or has just been) applied.
  task automatic checkReset(input int t);
    chk("rst_data_req", t, 64'(data_req), 64'd0);
    chk("rst_camsub", t, 64'(CAMSUB_req), 64'd0);
    chk("rst_findsub", t, 64'(FindSub_req), 64'd0);
    chk("rst_finish", t, 64'(finish), 64'd0);
    chk("rst_addr", t, 64'(data_addr), 64'd0);
    chk("rst_xi", t, 64'(xi), 64'd0);
    chk("rst_xmax", t, o_xmax_MV, 64'd0);
    chk("rst_oxi", t, o_xi_MV, 64'd0);
    chk("rst_osub", t, o_sub_MV, 64'd0);
    chk("rst_osum", t, o_sum_MV, 64'd0);
  endtask

  // Expected outputs for cycle t after IDLE exit (vector t/50, phase t%50).
  task automatic checkOutput(input int t);
    int v, p;
    logic [63:0] eReq, eCam, eFind, eFin, eAddr, eXi, eXmax, eOxi, eOsub, eSum;
    v = t / 50;
    p = t % 50;
    if (t >= 800) begin
      eReq = 0; eCam = 0; eFind = 0; eFin = 1; eAddr = 64'd255; eXi = 0;
      eXmax = xmaxModel(15);
      eOxi  = camModel(mem[255]);
      eOsub = subTab[15][15];
      eSum  = sumModel(15);
    end else begin
      eFin  = 0;
      eReq  = (p < 16) ? 64'd1 : 64'd0;
      eCam  = (p >= 16 && p < 32) ? 64'd1 : 64'd0;
      eFind = (p >= 33 && p < 49) ? 64'd1 : 64'd0;
      eAddr = (p < 16) ? 64'(16 * v + p) : 64'(16 * v + 15);
      eXi   = 64'd0;
      if (p >= 16 && p < 32) eXi = 64'(mem[16 * v + p - 16]);
      if (p >= 33 && p < 49) eXi = 64'(mem[16 * v + p - 33]);
      if (p >= 32)      eXmax = xmaxModel(v);
      else if (v == 0)  eXmax = 64'd0;
      else              eXmax = xmaxModel(v - 1);
      if (p >= 17 && p < 32) eOxi = camModel(mem[16 * v + p - 17]);
      else if (p >= 32)      eOxi = camModel(mem[16 * v + 15]);
      else if (v == 0)       eOxi = 64'd0;
      else                   eOxi = camModel(mem[16 * v - 1]);
      if (p >= 35)      eOsub = subTab[v][p - 35];
      else if (v == 0)  eOsub = 64'd0;
      else              eOsub = subTab[v - 1][15];
      eSum = (v == 0) ? 64'd0 : sumModel(v - 1);
    end
    chk("data_req", t, 64'(data_req), eReq);
    chk("CAMSUB_req", t, 64'(CAMSUB_req), eCam);
    chk("FindSub_req", t, 64'(FindSub_req), eFind);
    chk("finish", t, 64'(finish), eFin);
    chk("data_addr", t, 64'(data_addr), eAddr);
    chk("xi", t, 64'(xi), eXi);
    chk("o_xmax_MV", t, o_xmax_MV, eXmax);
    chk("o_xi_MV", t, o_xi_MV, eOxi);
    chk("o_sub_MV", t, o_sub_MV, eOsub);
    chk("o_sum_MV", t, o_sum_MV, eSum);
  endtask

  // Returns are only meaningful in the cycle after each FindSub_req cycle
  // (phases 34..49); every other cycle gets random junk.
  task automatic applyStimulus(input int t);
    int v, p;
    v = t / 50;
    p = t % 50;
    junkXi = {$urandom, $urandom};
    if (t < 800 && p >= 34) begin
      expIn = expTab[v][p - 34];
      subIn = subTab[v][p - 34];
    end else begin
      expIn = 8'($urandom);
      subIn = {$urandom, $urandom};
    end
  endtask

  initial begin
    // Vector contents: vector 0 fixed, vector 2 entirely out of CAM range,
    // the rest random around the CAM window.
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 79) - 30);
    for (int a = 0; a < 16; a++) mem[a] = 8'd0;
    mem[0] = 8'hEC;
    mem[1] = 8'd5;
    mem[2] = 8'd43;
    for (int a = 32; a < 48; a++) mem[a] = 8'd100;
    for (int v = 0; v < 16; v++) begin
      for (int j = 0; j < 16; j++) begin
        expTab[v][j] = 8'($urandom_range(0, 3));
        subTab[v][j] = {$urandom, $urandom};
      end
    end
    for (int j = 0; j < 16; j++) expTab[0][j] = 8'd1;
    for (int j = 0; j < 16; j++) expTab[5][j] = 8'd255;

    sumExpIn = 8'd3;
    expIn    = 8'd0;
    subIn    = 64'd0;
    junkXi   = 64'd0;

    // Reset held for two cycles.
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkReset(-1);
    reset = 1'b0;
    #1 checkReset(-1);

    // Full run through DONE, with a few cycles past it.
    for (int t = 0; t <= 805; t++) begin
      @(negedge clk);
      checkOutput(t);
      applyStimulus(t);
    end

    // Second run with a larger offset, aborted during FINDSUB of vector 3.
    sumExpIn = 8'd40;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t <= 188; t++) begin
      @(negedge clk);
      checkOutput(t);
      applyStimulus(t);
    end
    #2 reset = 1'b1;
    #1 checkReset(188);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 checkReset(-1);

    // Restart must begin again at address 0.
    for (int t = 0; t <= 120; t++) begin
      @(negedge clk);
      checkOutput(t);
      applyStimulus(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
